// File: rtl/pipe_hazard_ctrl.sv
// Pipeline latch enable/flush control for the 5-stage diaosi pipeline: memory-wait,
// load-use, MEM-stage redirect and halt handling. Define PIPE_HAZARD_PERF_EN for perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_taken,
  input  logic             mem_halt,
  input  logic             idex_dren,
  input  logic [REG_W-1:0] idex_wsel,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             dmem_ren,
  output logic             dmem_wen,
  output logic             halted
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t state, state_next;
  logic   dmem_done;
  logic   mem_req, mem_ok, running, advance, load_use;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  assign mem_req  = mem_dren | mem_dwen;
  assign mem_ok   = !mem_req | dhit | dmem_done;
  assign running  = (state == RUN);
  assign advance  = running & ihit & mem_ok;
  assign load_use = idex_dren && (idex_wsel != '0) &&
                    ((idex_wsel == ifid_rs) || (ifid_uses_rt && (idex_wsel == ifid_rt)));

  // A finished data access must not be re-issued while fetch is still stalling.
  assign dmem_ren = mem_dren & !dmem_done & running;
  assign dmem_wen = mem_dwen & !dmem_done & running;
  assign halted   = (state == HALT);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; nRST sits in the sensitivity list to make the clear asynchronous.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      dmem_done <= 1'b0;
    end else begin
      state <= state_next;
      if (advance)
        dmem_done <= 1'b0;
      else if (mem_req && dhit)
        dmem_done <= 1'b1;
    end
  end

  // NOTE: every output gets a default before any branch, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (advance) begin
      if (mem_halt) begin
        // Halt retires through WB; everything younger is squashed.
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        state_next  = HALT;
      end else if (mem_taken) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID for one cycle, push a bubble into EX.
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        idex_flush  = 1'b1;
      end else begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
      loaduse_cnt  <= '0;
      flush_cnt    <= '0;
    end else begin
      if (running && !advance)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (advance && !mem_halt && !mem_taken && load_use)
        loaduse_cnt <= loaduse_cnt + CNT_W'(1);
      if (advance && !mem_halt && mem_taken)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed stimulus with expected control
// vectors queued at drive time and compared at the following falling edge.
module tb_pipe_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, mem_dren, mem_dwen, mem_taken, mem_halt;
  logic       idex_dren, ifid_uses_rt;
  logic [4:0] idex_wsel, ifid_rs, ifid_rt;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic       dmem_ren, dmem_wen, halted;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl,
  //  dmem_ren, dmem_wen, halted}
  logic [11:0] obs;
  assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush,
                dmem_ren, dmem_wen, halted};

  localparam logic [11:0] IDLE     = 12'h000;
  localparam logic [11:0] ADV      = 12'hF80;
  localparam logic [11:0] REN      = 12'h004;
  localparam logic [11:0] WEN      = 12'h002;
  localparam logic [11:0] LU       = 12'h1A0;
  localparam logic [11:0] LU_MASK  = 12'hDFF;
  localparam logic [11:0] BR       = 12'h8F0;
  localparam logic [11:0] BR_MASK  = 12'h8FF;
  localparam logic [11:0] HALT_TRG = 12'h0F0;
  localparam logic [11:0] HALTED   = 12'h001;
  localparam logic [11:0] ALL      = 12'hFFF;

  typedef struct {
    string       tag;
    logic [11:0] exp;
    logic [11:0] mask;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_taken(mem_taken), .mem_halt(mem_halt),
    .idex_dren(idex_dren), .idex_wsel(idex_wsel), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %03h want %03h", tag, got, want);
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      check(e.tag, obs & e.mask, e.exp & e.mask);
    end
  end

  task automatic set_in(input logic ih, input logic dh, input logic dr, input logic dw,
                        input logic tk, input logic hl, input logic ld,
                        input logic [4:0] ws, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt);
    ihit = ih; dhit = dh; mem_dren = dr; mem_dwen = dw; mem_taken = tk; mem_halt = hl;
    idex_dren = ld; idex_wsel = ws; ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = urt;
  endtask

  // Drive one cycle of inputs, queue its expectation, and move past the next rising edge.
  task automatic cyc(input string tag, input logic ih, input logic dh, input logic dr,
                     input logic dw, input logic tk, input logic hl, input logic ld,
                     input logic [4:0] ws, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic [11:0] exp, input logic [11:0] mask);
    sb_t e;
    set_in(ih, dh, dr, dw, tk, hl, ld, ws, rs, rt, urt);
    e.tag = tag; e.exp = exp; e.mask = mask;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    #1;
    check("reset_run_adv", obs, ADV);
    ihit = 1'b0;
    #1;
    check("reset_idle", obs, IDLE);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Memory wait: data completes first, fetch later
    cyc("mw_c1",   0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, REN,  ALL);
    cyc("mw_c2",   0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, REN,  ALL);
    cyc("mw_c3",   0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, IDLE, ALL);
    cyc("mw_c4",   0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, IDLE, ALL);
    cyc("mw_c5",   1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, ADV,  ALL);
    cyc("mw_c6",   0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, REN,  ALL);
    cyc("mw_ifwt", 1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, REN,  ALL);
    cyc("mw_done", 1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, ADV | REN, ALL);

    // Store with simultaneous hits: advance without latching dmem_done
    cyc("st_both", 1, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, ADV | WEN, ALL);
    cyc("st_next", 0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, WEN, ALL);
    cyc("st_end",  1, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, ADV | WEN, ALL);

    // Load-use on rs, then the bubble has left EX
    cyc("lu_rs",     1, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd2, 0, LU,  LU_MASK);
    cyc("lu_after",  1, 0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd2, 0, ADV, ALL);
    cyc("lu_rt",     1, 0, 0, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 1, LU,  LU_MASK);
    cyc("lu_rt_off", 1, 0, 0, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, ADV, ALL);
    cyc("lu_zero",   1, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, ADV, ALL);
    cyc("lu_nohit",  0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd2, 0, IDLE, ALL);

    // Redirect in MEM beats load-use
    cyc("br_lu",    1, 0, 0, 0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, BR,   BR_MASK);
    cyc("br_nohit", 0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, IDLE, ALL);

    // Async reset while dmem_done is set
    cyc("ar_hit",  0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, REN,  ALL);
    cyc("ar_wait", 0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, IDLE, ALL);
    set_in(0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    #2;
    check("ar_pre", obs, IDLE);
    nRST = 1'b0;
    #1;
    check("ar_in_reset", obs, REN);
    #1;
    nRST = 1'b1;
    #1;
    check("ar_released", obs, REN);
    @(posedge CLK);
    #1;

    // Halt and the frozen HALT state
    cyc("halt_trg", 1, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, HALT_TRG, ALL);
    cyc("halt_h1",  1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, HALTED, ALL);
    cyc("halt_h2",  0, 1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, HALTED, ALL);
    cyc("halt_h3",  1, 0, 1, 1, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, HALTED, ALL);
    cyc("halt_h4",  1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, HALTED, ALL);
    set_in(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    #2;
    nRST = 1'b0;
    #1;
    check("halt_reset", obs, ADV);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    cyc("post_halt", 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, ADV, ALL);

    check("sb_drained", {11'd0, sb.size() == 0}, 12'h001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
